// File: rtl/axi_lite_ch_fifo.sv
// AXI-lite channel buffer: DEPTH-entry FIFO between a valid/ready slave port and master port.
// Ready and valid are registered from the word count; m_data is a registered head-of-queue copy.
module axi_lite_ch_fifo #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       anreset,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [DATA_W-1:0]          s_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [DATA_W-1:0]          m_data,
   output logic                       cs_in,
   output logic                       cs_out,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  count_after_rd;
   logic              s_ready_q, s_ready_d;
   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic              wr_en, rd_en;

   assign wr_en = s_valid & s_ready_q;
   assign rd_en = m_valid_q & m_ready;

   // Next-state: pointers, count, and the head word visible after this edge.
   always_comb begin
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      count_d        = count_q;
      m_data_d       = m_data_q;
      s_ready_d      = s_ready_q;
      m_valid_d      = m_valid_q;
      count_after_rd = count_q - CNT_W'(rd_en);

      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // When the queue drains to nothing but this write, the head is the incoming word.
      if (count_d != CNT_W'(0)) begin
         if (count_after_rd == CNT_W'(0)) m_data_d = s_data;
         else                             m_data_d = mem_q[rd_ptr_d];
      end

      s_ready_d = (count_d != CNT_W'(DEPTH));
      m_valid_d = (count_d != CNT_W'(0));
   end

   always_ff @(posedge clk or negedge anreset) begin
      if (!anreset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         s_ready_q <= 1'b1;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         s_ready_q <= s_ready_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= s_data;
   end

   assign s_ready = s_ready_q;
   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign count   = count_q;
   assign cs_in   = wr_en;
   assign cs_out  = rd_en;

endmodule

// File: tb/tb_axi_lite_ch_fifo.sv
// Directed bench for axi_lite_ch_fifo (DATA_W=8, DEPTH=4) with hand-computed expectations.
module tb_axi_lite_ch_fifo;

   logic       clk = 1'b0;
   logic       anreset;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic       cs_in;
   logic       cs_out;
   logic [2:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   // {s_ready, m_valid, count, m_data}
   logic [12:0] st;
   logic [1:0]  cs;
   assign st = {s_ready, m_valid, count, m_data};
   assign cs = {cs_in, cs_out};

   axi_lite_ch_fifo #(.DATA_W(8), .DEPTH(4)) dut (
      .clk     (clk),
      .anreset (anreset),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .cs_in   (cs_in),
      .cs_out  (cs_out),
      .count   (count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      anreset = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 8'h00;
      #12;
      n_checks++;
      if (st !== {1'b1, 1'b0, 3'd0, 8'h00}) begin n_fail++; $display("FAIL reset_status: got %h want %h", st, {1'b1, 1'b0, 3'd0, 8'h00}); end
      n_checks++;
      if (cs !== 2'b00) begin n_fail++; $display("FAIL reset_cs: got %b want 00", cs); end
      @(negedge clk);
      anreset = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (st !== {1'b1, 1'b0, 3'd0, 8'h00}) begin n_fail++; $display("FAIL idle_status[%0d]: got %h want %h", i, st, {1'b1, 1'b0, 3'd0, 8'h00}); end
         tick();
      end
   endtask

   task automatic test_single();
      s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
      #1;
      n_checks++;
      if (cs !== 2'b10) begin n_fail++; $display("FAIL single_cs_in: got %b want 10", cs); end
      tick();
      s_valid = 1'b0; s_data = 8'hFF;
      #1;
      n_checks++;
      if (st !== {1'b1, 1'b1, 3'd1, 8'hA5}) begin n_fail++; $display("FAIL single_head: got %h want %h", st, {1'b1, 1'b1, 3'd1, 8'hA5}); end
      n_checks++;
      if (cs !== 2'b01) begin n_fail++; $display("FAIL single_cs_out: got %b want 01", cs); end
      tick();
      m_ready = 1'b0;
      n_checks++;
      if (st !== {1'b1, 1'b0, 3'd0, 8'hA5}) begin n_fail++; $display("FAIL single_drained: got %h want %h", st, {1'b1, 1'b0, 3'd0, 8'hA5}); end
   endtask

   task automatic test_fill();
      m_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         s_valid = 1'b1; s_data = 8'(i);
         #1;
         n_checks++;
         if (cs_in !== (i <= 4)) begin n_fail++; $display("FAIL fill_cs_in[%0d]: got %b want %b", i, cs_in, (i <= 4)); end
         tick();
      end
      #1;
      n_checks++;
      if (st !== {1'b0, 1'b1, 3'd4, 8'h01}) begin n_fail++; $display("FAIL fill_full: got %h want %h", st, {1'b0, 1'b1, 3'd4, 8'h01}); end
      n_checks++;
      if (cs !== 2'b00) begin n_fail++; $display("FAIL fill_blocked_cs: got %b want 00", cs); end
      m_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_checks++;
         if ({m_valid, m_data} !== {1'b1, 8'(k + 1)}) begin n_fail++; $display("FAIL fill_pop[%0d]: got %h want %h", k, {m_valid, m_data}, {1'b1, 8'(k + 1)}); end
         n_checks++;
         if (cs !== {(k == 1), 1'b1}) begin n_fail++; $display("FAIL fill_pop_cs[%0d]: got %b want %b", k, cs, {(k == 1), 1'b1}); end
         tick();
         if (k == 1) s_valid = 1'b0;
      end
      m_ready = 1'b0;
      #1;
      n_checks++;
      if (st !== {1'b1, 1'b0, 3'd0, 8'h05}) begin n_fail++; $display("FAIL fill_empty: got %h want %h", st, {1'b1, 1'b0, 3'd0, 8'h05}); end
   endtask

   task automatic test_back_to_back();
      s_valid = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         s_data = 8'(16 + i);
         #1;
         n_checks++;
         if (cs !== {1'b1, (i > 0)}) begin n_fail++; $display("FAIL stream_cs[%0d]: got %b want %b", i, cs, {1'b1, (i > 0)}); end
         if (i > 0) begin
            n_checks++;
            if ({count, m_data} !== {3'd1, 8'(15 + i)}) begin n_fail++; $display("FAIL stream_head[%0d]: got %h want %h", i, {count, m_data}, {3'd1, 8'(15 + i)}); end
         end
         tick();
      end
      s_valid = 1'b0;
      #1;
      n_checks++;
      if (st !== {1'b1, 1'b1, 3'd1, 8'h19}) begin n_fail++; $display("FAIL stream_last: got %h want %h", st, {1'b1, 1'b1, 3'd1, 8'h19}); end
      n_checks++;
      if (cs !== 2'b01) begin n_fail++; $display("FAIL stream_last_cs: got %b want 01", cs); end
      tick();
      m_ready = 1'b0;
      n_checks++;
      if (st !== {1'b1, 1'b0, 3'd0, 8'h19}) begin n_fail++; $display("FAIL stream_drained: got %h want %h", st, {1'b1, 1'b0, 3'd0, 8'h19}); end
   endtask

   task automatic test_backpressure();
      s_valid = 1'b1; s_data = 8'h33; m_ready = 1'b0;
      tick();
      s_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_data = 8'($urandom);
         #1;
         n_checks++;
         if (st !== {1'b1, 1'b1, 3'd1, 8'h33}) begin n_fail++; $display("FAIL hold_status[%0d]: got %h want %h", i, st, {1'b1, 1'b1, 3'd1, 8'h33}); end
         n_checks++;
         if (cs !== 2'b00) begin n_fail++; $display("FAIL hold_cs[%0d]: got %b want 00", i, cs); end
         tick();
      end
      m_ready = 1'b1;
      #1;
      n_checks++;
      if (cs !== 2'b01) begin n_fail++; $display("FAIL hold_release_cs: got %b want 01", cs); end
      tick();
      m_ready = 1'b0;
      n_checks++;
      if (st !== {1'b1, 1'b0, 3'd0, 8'h33}) begin n_fail++; $display("FAIL hold_drained: got %h want %h", st, {1'b1, 1'b0, 3'd0, 8'h33}); end
   endtask

   task automatic test_reset_mid();
      m_ready = 1'b0; s_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_data = 8'(8'hA1 + i);
         tick();
      end
      s_valid = 1'b0;
      #1;
      n_checks++;
      if (st !== {1'b1, 1'b1, 3'd3, 8'hA1}) begin n_fail++; $display("FAIL rstmid_pre: got %h want %h", st, {1'b1, 1'b1, 3'd3, 8'hA1}); end
      #2;
      anreset = 1'b0;
      #1;
      n_checks++;
      if (st !== {1'b1, 1'b0, 3'd0, 8'h00}) begin n_fail++; $display("FAIL rstmid_async: got %h want %h", st, {1'b1, 1'b0, 3'd0, 8'h00}); end
      n_checks++;
      if (cs !== 2'b00) begin n_fail++; $display("FAIL rstmid_cs: got %b want 00", cs); end
      @(negedge clk);
      anreset = 1'b1;
      tick();
      n_checks++;
      if (st !== {1'b1, 1'b0, 3'd0, 8'h00}) begin n_fail++; $display("FAIL rstmid_idle: got %h want %h", st, {1'b1, 1'b0, 3'd0, 8'h00}); end
      s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b1;
      tick();
      s_valid = 1'b0;
      #1;
      n_checks++;
      if (st !== {1'b1, 1'b1, 3'd1, 8'h77}) begin n_fail++; $display("FAIL rstmid_fresh: got %h want %h", st, {1'b1, 1'b1, 3'd1, 8'h77}); end
      n_checks++;
      if (cs !== 2'b01) begin n_fail++; $display("FAIL rstmid_fresh_cs: got %b want 01", cs); end
      tick();
      m_ready = 1'b0;
      n_checks++;
      if (st !== {1'b1, 1'b0, 3'd0, 8'h77}) begin n_fail++; $display("FAIL rstmid_drained: got %h want %h", st, {1'b1, 1'b0, 3'd0, 8'h77}); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
